// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature decoder: Gray-code states, the
// transition classifier and the filter counter sizing helper.
package quad_pkg;

  localparam logic [1:0] S00 = 2'b00;
  localparam logic [1:0] S01 = 2'b01;
  localparam logic [1:0] S11 = 2'b11;
  localparam logic [1:0] S10 = 2'b10;

  // Returns {legal, up}; a single-bit change along the Gray ring is legal.
  function automatic logic [1:0] quad_dir(input logic [1:0] prev, input logic [1:0] cur);
    logic legal;
    logic up;
    legal = 1'b0;
    up    = 1'b0;
    case (prev)
      S00: begin
        if (cur == S01) begin legal = 1'b1; up = 1'b1; end
        else if (cur == S10) legal = 1'b1;
      end
      S01: begin
        if (cur == S11) begin legal = 1'b1; up = 1'b1; end
        else if (cur == S00) legal = 1'b1;
      end
      S11: begin
        if (cur == S10) begin legal = 1'b1; up = 1'b1; end
        else if (cur == S01) legal = 1'b1;
      end
      default: begin
        if (cur == S00) begin legal = 1'b1; up = 1'b1; end
        else if (cur == S11) legal = 1'b1;
      end
    endcase
    return {legal, up};
  endfunction

  function automatic int filt_cnt_w(input int filt_len);
    return (filt_len < 1) ? 1 : $clog2(filt_len + 1);
  endfunction

endpackage

// File: rtl/quad_input_filter.sv
// Two-flop synchronizer followed by a stability filter: the output only
// follows the synchronized pin once it has held for FILT_LEN cycles.
module quad_input_filter
  import quad_pkg::*;
#(
  parameter int FILT_LEN = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pin,
  output logic o_filt
);

  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_pin;
      r_sync2 <= r_sync1;
    end
  end

  generate
    if (FILT_LEN == 0) begin : g_bypass
      assign o_filt = r_sync2;
    end else begin : g_filter
      localparam int CW = filt_cnt_w(FILT_LEN);
      localparam logic [CW-1:0] LAST = CW'(FILT_LEN - 1);

      logic [CW-1:0] r_cnt;
      logic          r_filt;

      // A bounce back to the accepted value restarts the count.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_cnt  <= '0;
          r_filt <= 1'b0;
        end else if (r_sync2 != r_filt) begin
          if (r_cnt == LAST) begin
            r_filt <= r_sync2;
            r_cnt  <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end else begin
          r_cnt <= '0;
        end
      end

      assign o_filt = r_filt;
    end
  endgenerate

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: filtered A/B/index pins drive a step strobe, a
// direction bit, a sticky error flag and a loadable wrapping position.
module quad_decoder
  import quad_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int FILT_LEN = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             enc_i,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             idx_clr_en,
  input  logic             err_clr,
  output logic [WIDTH-1:0] pos,
  output logic             step,
  output logic             dir,
  output logic             err
);

  logic w_a;
  logic w_b;
  logic w_idx;

  quad_input_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
    .clk(clk), .rst_n(rst_n), .i_pin(enc_a), .o_filt(w_a)
  );
  quad_input_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
    .clk(clk), .rst_n(rst_n), .i_pin(enc_b), .o_filt(w_b)
  );
  quad_input_filter #(.FILT_LEN(FILT_LEN)) u_filt_i (
    .clk(clk), .rst_n(rst_n), .i_pin(enc_i), .o_filt(w_idx)
  );

  logic             r_primed;
  logic [1:0]       r_prev_ab;
  logic             r_idx_prev;
  logic [WIDTH-1:0] r_pos;
  logic             r_step;
  logic             r_dir;
  logic             r_err;

  logic [1:0] w_ab;
  logic [1:0] w_qd;
  logic       w_changed;
  logic       w_legal;
  logic       w_illegal;
  logic       w_idx_rise;

  assign w_ab       = {w_a, w_b};
  assign w_qd       = quad_dir(r_prev_ab, w_ab);
  assign w_changed  = r_primed && (w_ab != r_prev_ab);
  assign w_legal    = w_changed && w_qd[1];
  assign w_illegal  = w_changed && !w_qd[1];
  assign w_idx_rise = w_idx && !r_idx_prev;

  // Load beats index clear beats counting; step/dir report the move regardless.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_primed   <= 1'b0;
      r_prev_ab  <= 2'b00;
      r_idx_prev <= 1'b0;
      r_pos      <= '0;
      r_step     <= 1'b0;
      r_dir      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_primed   <= 1'b1;
      r_prev_ab  <= w_ab;
      r_idx_prev <= w_idx;
      r_step     <= w_legal;
      if (w_legal) r_dir <= w_qd[0];

      if (w_illegal)    r_err <= 1'b1;
      else if (err_clr) r_err <= 1'b0;

      if (ld)                            r_pos <= ld_val;
      else if (idx_clr_en && w_idx_rise) r_pos <= '0;
      else if (w_legal)                  r_pos <= w_qd[0] ? r_pos + WIDTH'(1) : r_pos - WIDTH'(1);
    end
  end

  assign pos  = r_pos;
  assign step = r_step;
  assign dir  = r_dir;
  assign err  = r_err;

endmodule
